multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the processor datapath. Steps each instruction through fetch, decode, execute, memory and writeback. Drives the datapath control lines (RegDst, ALUsrc, ExtOp, MemToReg and the write enables) one phase at a time. Handshakes with instruction memory, data memory and the multi-cycle mul/div unit, and traps on illegal opcodes or bus timeouts.

---
 rtl/multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/MDWAIT/WB with bus-timeout and illegal-opcode trap.
// Datapath selects (reg_dst/alu_src/ext_op/mem_to_reg) are registered at decode; strobes decode from state.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [4:0] opcode,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       md_done,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       ext_op,
  output logic       mem_to_reg,
  output logic       mem_read,
  output logic       mem_write,
  output logic       md_start,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MDWAIT, S_WB, S_TRAP
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b00001;
  localparam logic [4:0] OP_SW   = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_ANDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_BNQ  = 5'b01001;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_XOR  = 5'b01111;

  state_t          r_state;
  state_t          w_next_state;
  logic [4:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_cause;
  logic            r_reg_dst;
  logic            r_alu_src;
  logic            r_ext_op;
  logic            r_mem_to_reg;

  logic            w_legal;
  logic            w_dec_rtype;
  logic            w_dec_lw;
  logic            w_dec_sw;
  logic            w_dec_andi;
  logic            w_dec_bnq;
  logic            w_op_lw;
  logic            w_op_sw;
  logic            w_op_bnq;
  logic            w_op_md;
  logic            w_cnt_last;
  logic            w_counting;

  // Decode of the live opcode; only meaningful in DECODE.
  always_comb begin
    w_legal     = 1'b0;
    w_dec_rtype = 1'b0;
    case (opcode)
      OP_ADD, OP_AND, OP_SUB, OP_MUL, OP_DIV, OP_XOR: begin
        w_legal     = 1'b1;
        w_dec_rtype = 1'b1;
      end
      OP_LW, OP_SW, OP_ANDI, OP_BNQ: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_dec_lw   = (opcode == OP_LW);
  assign w_dec_sw   = (opcode == OP_SW);
  assign w_dec_andi = (opcode == OP_ANDI);
  assign w_dec_bnq  = (opcode == OP_BNQ);

  assign w_op_lw  = (r_op == OP_LW);
  assign w_op_sw  = (r_op == OP_SW);
  assign w_op_bnq = (r_op == OP_BNQ);
  assign w_op_md  = (r_op == OP_MUL) || (r_op == OP_DIV);

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_counting = ((r_state == S_FETCH) && run) || (r_state == S_MEM) || (r_state == S_MDWAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A ready/done in the last allowed wait cycle takes precedence over the timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (run) begin
          if (imem_ready)      w_next_state = S_DECODE;
          else if (w_cnt_last) w_next_state = S_TRAP;
        end
      end
      S_DECODE: w_next_state = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (w_op_bnq)                w_next_state = S_FETCH;
        else if (w_op_lw || w_op_sw) w_next_state = S_MEM;
        else if (w_op_md)            w_next_state = S_MDWAIT;
        else                         w_next_state = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)      w_next_state = w_op_lw ? S_WB : S_FETCH;
        else if (w_cnt_last) w_next_state = S_TRAP;
      end
      S_MDWAIT: begin
        if (md_done)         w_next_state = S_WB;
        else if (w_cnt_last) w_next_state = S_TRAP;
      end
      S_WB:    w_next_state = S_FETCH;
      S_TRAP:  w_next_state = S_TRAP;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= 5'b0;
      r_cnt        <= '0;
      r_cause      <= 2'b00;
      r_reg_dst    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_ext_op     <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else begin
      if (r_state == S_DECODE) begin
        r_op <= opcode;
      end
      if ((w_next_state != r_state) || !w_counting) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state != S_TRAP) && (w_next_state == S_TRAP)) begin
        r_cause <= (r_state == S_DECODE) ? 2'b01 : 2'b10;
      end
      if ((r_state == S_DECODE) && (w_next_state == S_EXEC)) begin
        r_reg_dst    <= w_dec_rtype;
        r_alu_src    <= w_dec_andi || w_dec_lw || w_dec_sw;
        r_ext_op     <= w_dec_lw || w_dec_sw || w_dec_bnq;
        r_mem_to_reg <= w_dec_lw;
      end else if ((w_next_state == S_FETCH) || (w_next_state == S_TRAP)) begin
        r_reg_dst    <= 1'b0;
        r_alu_src    <= 1'b0;
        r_ext_op     <= 1'b0;
        r_mem_to_reg <= 1'b0;
      end
    end
  end

  // zero steers the PC mux in the datapath; branch only enables that selection.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    md_start   = 1'b0;
    retire     = 1'b0;
    trap       = 1'b0;
    trap_cause = 2'b00;
    if (!rst) begin
      reg_dst    = r_reg_dst;
      alu_src    = r_alu_src;
      ext_op     = r_ext_op;
      mem_to_reg = r_mem_to_reg;
      case (r_state)
        S_FETCH: begin
          imem_req = run;
          ir_write = run && imem_ready;
        end
        S_EXEC: begin
          if (w_op_bnq) begin
            branch   = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
          end
          md_start = w_op_md;
        end
        S_MEM: begin
          mem_read  = w_op_lw;
          mem_write = w_op_sw;
          if (w_op_sw && dmem_ready) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          retire    = 1'b1;
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = r_cause;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instance 0 uses TIMEOUT=16, instance 1 uses TIMEOUT=4.
// Output vector bit order: imem_req ir_write pc_write branch reg_write reg_dst alu_src ext_op mem_to_reg mem_read mem_write md_start retire trap cause[1:0]
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic [4:0] opcode;
  logic       zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       md_done;

  logic [1:0] imem_req, ir_write, pc_write, branch, reg_write, reg_dst, alu_src;
  logic [1:0] ext_op, mem_to_reg, mem_read, mem_write, md_start, retire, trap;
  logic [3:0] cause_all;
  logic [15:0] w_out [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multicycle_ctrl #(.TIMEOUT(g == 0 ? 16 : 4)) u_dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .md_done(md_done),
      .imem_req(imem_req[g]), .ir_write(ir_write[g]), .pc_write(pc_write[g]),
      .branch(branch[g]), .reg_write(reg_write[g]), .reg_dst(reg_dst[g]),
      .alu_src(alu_src[g]), .ext_op(ext_op[g]), .mem_to_reg(mem_to_reg[g]),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]), .md_start(md_start[g]),
      .retire(retire[g]), .trap(trap[g]), .trap_cause(cause_all[2*g +: 2])
    );
    assign w_out[g] = {imem_req[g], ir_write[g], pc_write[g], branch[g], reg_write[g],
                       reg_dst[g], alu_src[g], ext_op[g], mem_to_reg[g], mem_read[g],
                       mem_write[g], md_start[g], retire[g], trap[g], cause_all[2*g +: 2]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive {run, imem_ready, dmem_ready, md_done, zero} for one cycle and sample both instances mid-cycle.
  task automatic cyc(input logic [4:0] iv, output logic [15:0] oa, output logic [15:0] ob);
    {run, imem_ready, dmem_ready, md_done, zero} = iv;
    #2;
    oa = w_out[0];
    ob = w_out[1];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] oa, ob;
    rst = 1'b1;
    opcode = 5'b00000;
    for (int i = 0; i < 2; i++) begin
      cyc(5'b11000, oa, ob);
      checks++;
      if (oa !== 16'h0000) begin errors++; $display("FAIL reset_a cyc%0d got %h exp 0000", i + 1, oa); end
      checks++;
      if (ob !== 16'h0000) begin errors++; $display("FAIL reset_b cyc%0d got %h exp 0000", i + 1, ob); end
    end
    rst = 1'b0;
    cyc(5'b00000, oa, ob);
    checks++;
    if (oa !== 16'h0000) begin errors++; $display("FAIL reset_idle got %h exp 0000", oa); end
  endtask

  task automatic test_alu();
    logic [4:0]  iv [5] = '{5'b11000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    logic [15:0] ev [5] = '{16'hC000, 16'h0000, 16'h0400, 16'h2C08, 16'h0000};
    logic [15:0] oa, ob;
    opcode = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      cyc(iv[i], oa, ob);
      checks++;
      if (oa !== ev[i]) begin errors++; $display("FAIL alu cyc%0d got %h exp %h", i + 1, oa, ev[i]); end
    end
  endtask

  task automatic test_andi();
    logic [4:0]  iv [5] = '{5'b11000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    logic [15:0] ev [5] = '{16'hC000, 16'h0000, 16'h0200, 16'h2A08, 16'h0000};
    logic [15:0] oa, ob;
    opcode = 5'b00101;
    for (int i = 0; i < 5; i++) begin
      cyc(iv[i], oa, ob);
      checks++;
      if (oa !== ev[i]) begin errors++; $display("FAIL andi cyc%0d got %h exp %h", i + 1, oa, ev[i]); end
    end
  endtask

  task automatic test_lw();
    logic [4:0]  iv [9] = '{5'b11000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                            5'b00000, 5'b00100, 5'b00000, 5'b00000};
    logic [15:0] ev [9] = '{16'hC000, 16'h0000, 16'h0380, 16'h03C0, 16'h03C0,
                            16'h03C0, 16'h03C0, 16'h2B88, 16'h0000};
    logic [15:0] oa, ob;
    opcode = 5'b00001;
    for (int i = 0; i < 9; i++) begin
      cyc(iv[i], oa, ob);
      checks++;
      if (oa !== ev[i]) begin errors++; $display("FAIL lw cyc%0d got %h exp %h", i + 1, oa, ev[i]); end
    end
  endtask

  task automatic test_sw();
    logic [4:0]  iv [5] = '{5'b11000, 5'b00000, 5'b00000, 5'b00100, 5'b00000};
    logic [15:0] ev [5] = '{16'hC000, 16'h0000, 16'h0300, 16'h2328, 16'h0000};
    logic [15:0] oa, ob;
    opcode = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      cyc(iv[i], oa, ob);
      checks++;
      if (oa !== ev[i]) begin errors++; $display("FAIL sw cyc%0d got %h exp %h", i + 1, oa, ev[i]); end
    end
  endtask

  task automatic test_bnq();
    logic [15:0] ev [4] = '{16'hC000, 16'h0000, 16'h3108, 16'h0000};
    logic [4:0]  iv [4];
    logic [15:0] oa, ob;
    opcode = 5'b01001;
    for (int z = 0; z < 2; z++) begin
      iv = '{5'b11000, 5'b00000, {4'b0000, z[0]}, 5'b00000};
      for (int i = 0; i < 4; i++) begin
        cyc(iv[i], oa, ob);
        checks++;
        if (oa !== ev[i]) begin errors++; $display("FAIL bnq_z%0d cyc%0d got %h exp %h", z, i + 1, oa, ev[i]); end
      end
    end
  endtask

  task automatic test_mul();
    logic [4:0]  iv [10] = '{5'b11000, 5'b00000, 5'b00010, 5'b00000, 5'b00000,
                             5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000};
    logic [15:0] ev [10] = '{16'hC000, 16'h0000, 16'h0410, 16'h0400, 16'h0400,
                             16'h0400, 16'h0400, 16'h0400, 16'h2C08, 16'h0000};
    logic [15:0] oa, ob;
    opcode = 5'b01100;
    for (int i = 0; i < 10; i++) begin
      cyc(iv[i], oa, ob);
      checks++;
      if (oa !== ev[i]) begin errors++; $display("FAIL mul cyc%0d got %h exp %h", i + 1, oa, ev[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [4:0]  iv [4] = '{5'b11000, 5'b00000, 5'b11000, 5'b11000};
    logic [15:0] ev [4] = '{16'hC000, 16'h0000, 16'h0005, 16'h0005};
    logic [4:0]  ops [2] = '{5'b00011, 5'b10000};
    logic [15:0] oa, ob;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      for (int i = 0; i < 4; i++) begin
        cyc(iv[i], oa, ob);
        checks++;
        if (oa !== ev[i]) begin errors++; $display("FAIL illegal_%b cyc%0d got %h exp %h", ops[k], i + 1, oa, ev[i]); end
      end
      rst = 1'b1;
      cyc(5'b11000, oa, ob);
      checks++;
      if (oa !== 16'h0000) begin errors++; $display("FAIL illegal_rst got %h exp 0000", oa); end
      rst = 1'b0;
      cyc(5'b00000, oa, ob);
      checks++;
      if (oa !== 16'h0000) begin errors++; $display("FAIL illegal_after_rst_a got %h exp 0000", oa); end
      checks++;
      if (ob !== 16'h0000) begin errors++; $display("FAIL illegal_after_rst_b got %h exp 0000", ob); end
    end
  endtask

  task automatic test_timeout();
    logic [4:0]  iv1 [9] = '{5'b11000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                             5'b00000, 5'b00000, 5'b00000, 5'b00000};
    logic [15:0] ev1 [9] = '{16'hC000, 16'h0000, 16'h0300, 16'h0320, 16'h0320,
                             16'h0320, 16'h0320, 16'h0006, 16'h0006};
    logic [4:0]  iv2 [8] = '{5'b11000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                             5'b00000, 5'b00100, 5'b00000};
    logic [15:0] ev2 [8] = '{16'hC000, 16'h0000, 16'h0300, 16'h0320, 16'h0320,
                             16'h0320, 16'h2328, 16'h0000};
    logic [15:0] oa, ob;
    opcode = 5'b00010;
    for (int i = 0; i < 9; i++) begin
      cyc(iv1[i], oa, ob);
      checks++;
      if (ob !== ev1[i]) begin errors++; $display("FAIL timeout_mem cyc%0d got %h exp %h", i + 1, ob, ev1[i]); end
    end
    rst = 1'b1;
    cyc(5'b00000, oa, ob);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(iv2[i], oa, ob);
      checks++;
      if (ob !== ev2[i]) begin errors++; $display("FAIL timeout_edge cyc%0d got %h exp %h", i + 1, ob, ev2[i]); end
    end
  endtask

  task automatic test_fetch_timeout();
    logic [15:0] ev [5] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0006};
    logic [15:0] oa, ob;
    for (int i = 0; i < 5; i++) begin
      cyc(5'b10000, oa, ob);
      checks++;
      if (ob !== ev[i]) begin errors++; $display("FAIL fetch_timeout cyc%0d got %h exp %h", i + 1, ob, ev[i]); end
    end
    rst = 1'b1;
    cyc(5'b00000, oa, ob);
    rst = 1'b0;
    cyc(5'b00000, oa, ob);
    checks++;
    if (ob !== 16'h0000) begin errors++; $display("FAIL fetch_timeout_rst got %h exp 0000", ob); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  iv [9] = '{5'b11000, 5'b00000, 5'b00000, 5'b00000, 5'b11000,
                            5'b00000, 5'b00000, 5'b00000, 5'b00000};
    logic [15:0] ev [9] = '{16'hC000, 16'h0000, 16'h0400, 16'h2C08, 16'hC000,
                            16'h0000, 16'h0400, 16'h2C08, 16'h0000};
    logic [15:0] oa, ob;
    opcode = 5'b01111;
    for (int i = 0; i < 9; i++) begin
      cyc(iv[i], oa, ob);
      checks++;
      if (oa !== ev[i]) begin errors++; $display("FAIL back_to_back cyc%0d got %h exp %h", i + 1, oa, ev[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    opcode = 5'b00000;
    zero = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    md_done = 1'b0;
    test_reset();
    test_alu();
    test_andi();
    test_lw();
    test_sw();
    test_bnq();
    test_mul();
    test_illegal();
    test_timeout();
    test_fetch_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
